lv_spi_master: RTL



---
 rtl/lv_spi_pkg.sv | 36 +++
 rtl/lv_spi_clkgen.sv | 45 ++++
 rtl/lv_spi_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lv_spi_pkg.sv
// lv_spi_pkg: shared types and constants for the LV SPI master and slave.
// Frame layout (MSB first): {rw(1=write), addr[6:0], data[7:0]}.
package lv_spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int RW_BIT      = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } spi_state_e;

  typedef struct packed {
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] data;
  } spi_frame_t;

  // Build an outgoing frame; reads always carry a zero data byte.
  function automatic spi_frame_t make_frame(input logic                  wr,
                                            input logic [SPI_ADDR_W-1:0] addr,
                                            input logic [SPI_DATA_W-1:0] wdata);
    spi_frame_t f;
    f.rw   = wr;
    f.addr = addr;
    f.data = wr ? wdata : '0;
    return f;
  endfunction

endpackage

// File: rtl/lv_spi_clkgen.sv
// lv_spi_clkgen: SCLK half-period timer. While i_run is high it counts
// CLK_DIV i_clk cycles per half period and strobes the end of each half:
// o_rise_stb at the end of a low half, o_fall_stb at the end of a high half.
// Dropping i_run stops and clears the counter.
module lv_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_hi,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int                CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_done;

  assign half_done  = i_run && (cnt_q == LAST);
  assign o_rise_stb = half_done && !i_hi;
  assign o_fall_stb = half_done && i_hi;

  // Next count: restart at each half-period boundary or when stopped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q + 1'b1;
    if (!i_run || half_done) begin
      cnt_d = '0;
    end
  end

  // Half-period counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lv_spi_master.sv
// lv_spi_master: SPI mode-0 initiator for the LV register interface.
// Sends one 16-bit frame {rw, addr, data} MSB first per accepted request and
// returns the low byte shifted in on MISO for reads.
// Optional: define LV_SPI_MST_MISO_SYNC_EN to pass MISO through a 2-flop
// synchronizer and sample at the last i_clk cycle of SCLK high.
module lv_spi_master
  import lv_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int CSB_SETUP = 2,
  parameter int CSB_HOLD  = 2,
  parameter int CSB_GAP   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  output logic       o_ack,
  input  logic       i_wr,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_abort,
  output logic       o_busy,
  output logic [7:0] o_rdata,
  output logic       o_rdata_vld,
  output logic       o_spi_sclk,
  output logic       o_spi_csb,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso
);

  localparam int                 WAIT_W     = 8;
  localparam logic [WAIT_W-1:0]  SETUP_LAST = WAIT_W'(CSB_SETUP - 1);
  localparam logic [WAIT_W-1:0]  HOLD_LAST  = WAIT_W'(CSB_HOLD - 1);
  localparam logic [WAIT_W-1:0]  GAP_LAST   = WAIT_W'(CSB_GAP - 1);

  spi_state_e             state_q, state_d;
  logic [SPI_FRAME_W-1:0] tx_q, tx_d;
  logic [SPI_DATA_W-1:0]  rx_q, rx_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   rd_q, rd_d;
  logic                   aborted_q, aborted_d;
  logic                   ack_q, ack_d;
  logic [SPI_DATA_W-1:0]  rdata_q, rdata_d;
  logic                   vld_q, vld_d;

  logic clk_run, clk_hi, rise_stb, fall_stb;
  logic sample_stb, miso_s;
  logic csb_active;

  assign clk_run = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);
  assign clk_hi  = (state_q == SHIFT_HI);

  lv_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_run      (clk_run),
    .i_hi       (clk_hi),
    .o_rise_stb (rise_stb),
    .o_fall_stb (fall_stb)
  );

`ifdef LV_SPI_MST_MISO_SYNC_EN
  logic [1:0] miso_sync_q;

  // Two-flop MISO synchronizer; sampling waits until the end of SCLK high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      miso_sync_q <= 2'b00;
    end else begin
      miso_sync_q <= {miso_sync_q[0], i_spi_miso};
    end
  end

  assign miso_s     = miso_sync_q[1];
  assign sample_stb = fall_stb;

  if (CLK_DIV < 3) begin : g_clk_div_chk
    $error("lv_spi_master: CLK_DIV must be >= 3 when the MISO synchronizer is enabled");
  end
`else
  assign miso_s     = i_spi_miso;
  assign sample_stb = rise_stb;

  if (CLK_DIV < 2) begin : g_clk_div_chk
    $error("lv_spi_master: CLK_DIV must be >= 2");
  end
`endif

  // Next-state, shift-register and handshake logic.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    rd_d      = rd_q;
    aborted_d = aborted_q;
    ack_d     = 1'b0;
    vld_d     = 1'b0;
    rdata_d   = rdata_q;

    if (sample_stb) begin
      rx_d = {rx_q[SPI_DATA_W-2:0], miso_s};
    end

    case (state_q)
      IDLE: begin
        // A simultaneous abort has nothing to act on, so the request wins.
        if (i_req) begin
          tx_d      = make_frame(i_wr, i_addr, i_wdata);
          rd_d      = !i_wr;
          aborted_d = 1'b0;
          bit_cnt_d = '0;
          ack_d     = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (i_abort) begin
          aborted_d = 1'b1;
          state_d   = HOLD;
        end else if (wait_q == SETUP_LAST) begin
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (i_abort) begin
          aborted_d = 1'b1;
          state_d   = HOLD;
        end else if (rise_stb) begin
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (i_abort) begin
          aborted_d = 1'b1;
          state_d   = HOLD;
        end else if (fall_stb) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_d == 5'(SPI_FRAME_W)) begin
            state_d = HOLD;
          end else begin
            // MOSI advances only together with the SCLK fall.
            tx_d    = {tx_q[SPI_FRAME_W-2:0], 1'b0};
            state_d = SHIFT_LO;
          end
        end
      end
      HOLD: begin
        if (wait_q == HOLD_LAST) begin
          state_d = GAP;
          if (rd_q && !aborted_q) begin
            rdata_d = rx_q;
            vld_d   = 1'b1;
          end
        end
      end
      GAP: begin
        if (wait_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Dwell counter for SETUP/HOLD/GAP; restarts on every state change.
  always_comb begin
    wait_d = '0;
    if ((state_d == state_q) &&
        ((state_q == SETUP) || (state_q == HOLD) || (state_q == GAP))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
      rd_q      <= 1'b0;
      aborted_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
      rd_q      <= rd_d;
      aborted_q <= aborted_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      vld_q     <= vld_d;
    end
  end

  // SPI pins are decoded straight from state so reset clears them at once.
  assign csb_active  = (state_q == SETUP) || (state_q == SHIFT_LO) ||
                       (state_q == SHIFT_HI) || (state_q == HOLD);
  assign o_spi_csb   = !csb_active;
  assign o_spi_sclk  = (state_q == SHIFT_HI);
  assign o_spi_mosi  = csb_active && tx_q[RW_BIT];
  assign o_busy      = (state_q != IDLE);
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_rdata_vld = vld_q;

endmodule
